// File: rtl/x25519_freeze.sv
// Canonicalising "freeze" stage for X25519: maps 0 <= A < 2p to A mod p with a pipelined carry chain.
// Optional range_err output enabled by defining X25519_FREEZE_RANGE_CHECK_EN.
module x25519_freeze #(
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [263:0] a,
  output logic         out_valid,
  output logic [263:0] out
`ifdef X25519_FREEZE_RANGE_CHECK_EN
  ,
  output logic         range_err
`endif
);

  localparam int W = 264 / STAGES;
  // Adding 2^255 + 19 equals A - p + 2^256, so bit 256 of the sum flags A >= p.
  localparam logic [263:0] K = (264'd1 << 255) + 264'd19;

  if (!(STAGES == 1 || STAGES == 2 || STAGES == 4)) begin : g_bad_stages
    $error("x25519_freeze: STAGES must be 1, 2 or 4");
  end

  logic [263:0]      acc_in [STAGES];
  logic [263:0]      acc_d  [STAGES];
  logic [263:0]      acc_q  [STAGES];
  logic [255:0]      a_q    [STAGES];
  logic [STAGES-1:0] cin;
  logic [STAGES-1:0] cy_d;
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] vld_q;

  // Each stage replaces its chunk of the running word with the sum; higher chunks stay raw A.
  always_comb begin
    acc_in[0] = {8'b0, a[255:0]};
    cin[0]    = 1'b0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      acc_in[k] = acc_q[k-1];
      cin[k]    = cy_q[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc_d[k] = acc_in[k];
      {cy_d[k], acc_d[k][k*W +: W]} = (W+1)'(acc_in[k][k*W +: W]) + (W+1)'(K[k*W +: W])
                                      + (W+1)'(cin[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      acc_q[k] <= acc_d[k];
      cy_q[k]  <= cy_d[k];
    end
    a_q[0] <= a[255:0];
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_q[k] <= a_q[k-1];
    end
    if (rst) begin
      vld_q     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      vld_q[0] <= en;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      out_valid <= vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        out <= acc_q[STAGES-1][256] ? {9'b0, acc_q[STAGES-1][254:0]}
                                    : {8'b0, a_q[STAGES-1]};
      end
    end
  end

`ifdef X25519_FREEZE_RANGE_CHECK_EN
  localparam logic [255:0] LIMIT = 256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffda;

  logic              err_in;
  logic [STAGES-1:0] err_q;

  assign err_in = (a[263:256] != 8'd0) || (a[255:0] >= LIMIT);

  always_ff @(posedge clk) begin
    err_q[0] <= err_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      err_q[k] <= err_q[k-1];
    end
    if (rst) begin
      range_err <= 1'b0;
    end else if (vld_q[STAGES-1]) begin
      range_err <= err_q[STAGES-1];
    end
  end
`endif

  logic unused;
  assign unused = ^{a[263:256], cy_q[STAGES-1], acc_q[STAGES-1][263:257], acc_q[STAGES-1][255]};

endmodule
